int_div_seq_ctrl: RTL

//   Sequencing controller for the integer divider: accepts a dividend/divisor pair over a valid/ready handshake.

---
 rtl/int_div_seq_ctrl.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/int_div_seq_ctrl.sv
// ---------------------------------------------------------------------------
// int_div_seq_ctrl
//   Sequencing controller for an unsigned restoring integer divider.
//   Takes a dividend/divisor pair on a valid/ready handshake, then runs
//   WIDTH shift-subtract iterations (one quotient bit per clock). The
//   quotient and remainder are then offered on a valid/ready result
//   handshake. A zero divisor skips the iterations and returns
//   quotient = all ones, remainder = dividend, with div_by_zero set.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   in_valid     operand pair valid
//   in_ready     operands can be accepted (IDLE only)
//   dividend     unsigned dividend, sampled on accept
//   divisor      unsigned divisor, sampled on accept
//   out_valid    result valid (DONE only)
//   out_ready    consumer takes the result
//   quotient     registered quotient
//   remainder    registered remainder
//   div_by_zero  registered flag: result came from a zero divisor
//   busy         high while CALC or DONE
// ---------------------------------------------------------------------------
module int_div_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;       // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_reg, r_next;       // partial remainder
  logic [WIDTH-1:0] d_reg, d_next;       // latched divisor
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] quotient_reg, quotient_next;
  logic [WIDTH-1:0] remainder_reg, remainder_next;
  logic             dbz_reg, dbz_next;

  // One restoring step. The trial value is WIDTH+1 bits wide. The partial
  // remainder is always below the divisor, so it fits in WIDTH bits, and
  // so does any successful subtraction result. That lets the difference
  // be computed modulo 2^WIDTH without losing information.
  logic [WIDTH:0]   trial;
  logic             ge;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] r_step;

  assign trial  = {r_reg, q_reg[WIDTH-1]};
  assign ge     = (trial >= {1'b0, d_reg});
  assign diff   = trial[WIDTH-1:0] - d_reg;
  assign q_step = {q_reg[WIDTH-2:0], ge};
  assign r_step = ge ? diff : trial[WIDTH-1:0];

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      q_reg         <= '0;
      r_reg         <= '0;
      d_reg         <= '0;
      cnt_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      q_reg         <= q_next;
      r_reg         <= r_next;
      d_reg         <= d_next;
      cnt_reg       <= cnt_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
    end
  end

  // Next-state and datapath control
  always_comb begin
    state_next     = state_reg;
    q_next         = q_reg;
    r_next         = r_reg;
    d_next         = d_reg;
    cnt_next       = cnt_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;

    case (state_reg)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone marks an accept
        if (in_valid) begin
          if (divisor != '0) begin
            q_next     = dividend;
            r_next     = '0;
            d_next     = divisor;
            cnt_next   = CNT_W'(WIDTH - 1);
            state_next = CALC;
          end else begin
            quotient_next  = '1;
            remainder_next = dividend;
            dbz_next       = 1'b1;
            state_next     = DONE;
          end
        end
      end

      CALC: begin
        q_next   = q_step;
        r_next   = r_step;
        cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg == '0) begin
          // Final iteration: publish its result directly
          quotient_next  = q_step;
          remainder_next = r_step;
          dbz_next       = 1'b0;
          cnt_next       = '0;
          state_next     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign busy        = (state_reg != IDLE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule
